uart_tx_arbiter: RTL and testbench

- Shares one `uart_transmitter` between `NUM_REQ` byte producers, for example the AXI-lite register path, a debug console and a DMA feeder.
- Arbitrates round-robin, accepts one byte at a time over a valid/ready handshake, and drives the transmitter's `tx_data`/`tx_send` inputs.
- Sequences each byte by tracking the transmitter's `busy` output, so a byte is never dropped or issued while a frame is on the line.
- Sits between the requester logic and the transmitter instance inside the UART IP core.

---
 rtl/uart_pkg.sv | 12 +
 rtl/uart_tx_arbiter_if.sv | 31 +++
 rtl/uart_rr_picker.sv | 30 +++
 rtl/uart_tx_arbiter.sv | 116 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART TX arbiter: FSM state encoding and default byte width.
package uart_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_SEND = 2'd1,
    ARB_DONE = 2'd2
  } arb_state_e;

  localparam int DATA_UART_DEF = 8;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between the byte producers, the TX arbiter and the UART transmitter.
// The slave modport is the arbiter's view; master is the producers/transmitter view.
interface uart_tx_arbiter_if
  import uart_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_UART = DATA_UART_DEF
);

  logic                           en_i;
  logic [NUM_REQ-1:0]             req_valid_i;
  logic [NUM_REQ*DATA_UART-1:0]   req_data_i;
  logic [NUM_REQ-1:0]             req_last_i;
  logic [NUM_REQ-1:0]             req_ready_o;
  logic [DATA_UART-1:0]           tx_data_o;
  logic                           tx_send_o;
  logic                           tx_busy_i;
  logic [NUM_REQ-1:0]             grant_o;
  logic                           busy_o;

  modport slave (
    input  en_i, req_valid_i, req_data_i, req_last_i, tx_busy_i,
    output req_ready_o, tx_data_o, tx_send_o, grant_o, busy_o
  );

  modport master (
    output en_i, req_valid_i, req_data_i, req_last_i, tx_busy_i,
    input  req_ready_o, tx_data_o, tx_send_o, grant_o, busy_o
  );

endinterface

// File: rtl/uart_rr_picker.sv
// Combinational round-robin picker: first set request strictly after ptr, wrapping at NUM_REQ-1.
module uart_rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      idx,
  output logic               found
);

  logic [IW-1:0] k;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    k     = ptr;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = (k == IW'(NUM_REQ - 1)) ? '0 : k + IW'(1);
      if (!found && req[k]) begin
        found    = 1'b1;
        idx      = k;
        grant[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte producers.
// Optional packet lock is enabled by defining UART_TX_ARB_LOCK_EN.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_UART = DATA_UART_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  uart_tx_arbiter_if.slave  bus
);

  localparam int IW = $clog2(NUM_REQ);

  arb_state_e             state_q;
  logic [IW-1:0]          last_q;
  logic [IW-1:0]          pick_idx;
  logic [NUM_REQ-1:0]     eligible;
  logic [NUM_REQ-1:0]     pick_grant;
  logic [NUM_REQ-1:0]     grant_q;
  logic                   pick_found;
  logic                   accept;
  logic [DATA_UART-1:0]   tx_data_q;
  logic [DATA_UART-1:0]   win_data;
  logic                   tx_send_q;

`ifdef UART_TX_ARB_LOCK_EN
  logic                   lock_q;
  logic [IW-1:0]          owner_q;

  // While a packet is open only its owner may compete.
  assign eligible = lock_q ? (bus.req_valid_i & (NUM_REQ'(1) << owner_q)) : bus.req_valid_i;
`else
  logic                   unused_last;

  assign unused_last = ^bus.req_last_i;
  assign eligible    = bus.req_valid_i;
`endif

  uart_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_picker (
    .req   (eligible),
    .ptr   (last_q),
    .grant (pick_grant),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // A busy transmitter (including one held in reset) blocks acceptance.
  assign accept = (state_q == ARB_IDLE) && bus.en_i && !bus.tx_busy_i && pick_found;

  always_comb begin
    win_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (pick_idx == IW'(k)) win_data = bus.req_data_i[k*DATA_UART +: DATA_UART];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ARB_IDLE;
      tx_data_q <= '0;
      tx_send_q <= 1'b0;
      grant_q   <= '0;
      last_q    <= IW'(NUM_REQ - 1);
`ifdef UART_TX_ARB_LOCK_EN
      lock_q    <= 1'b0;
      owner_q   <= '0;
`endif
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (accept) begin
            tx_data_q <= win_data;
            tx_send_q <= 1'b1;
            grant_q   <= pick_grant;
            last_q    <= pick_idx;
            state_q   <= ARB_SEND;
`ifdef UART_TX_ARB_LOCK_EN
            if (bus.req_last_i[pick_idx]) begin
              lock_q  <= 1'b0;
            end else begin
              lock_q  <= 1'b1;
              owner_q <= pick_idx;
            end
`endif
          end
        end
        // Hold the send request, regardless of en_i, until the frame starts.
        ARB_SEND: begin
          if (bus.tx_busy_i) begin
            tx_send_q <= 1'b0;
            state_q   <= ARB_DONE;
          end
        end
        ARB_DONE: begin
          if (!bus.tx_busy_i) begin
            grant_q <= '0;
            state_q <= ARB_IDLE;
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  assign bus.req_ready_o = accept ? pick_grant : '0;
  assign bus.tx_data_o   = tx_data_q;
  assign bus.tx_send_o   = tx_send_q;
  assign bus.grant_o     = grant_q;
  assign bus.busy_o      = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus randomized streams
// checked against a queue-based round-robin reference model and a simple transmitter model.
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  localparam int N = 4;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(N), .DATA_UART(W)) bus ();

  uart_tx_arbiter #(.NUM_REQ(N), .DATA_UART(W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  // Transmitter model: busy while in reset, raises busy start_delay+1 edges after
  // seeing tx_send, then stays busy for frame_len cycles.
  int frame_len   = 3;
  int start_delay = 0;
  int busy_cnt;
  int wait_cnt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.tx_busy_i <= 1'b1;
      busy_cnt      <= 0;
      wait_cnt      <= 0;
    end else if (!bus.tx_busy_i) begin
      if (bus.tx_send_o) begin
        if (wait_cnt >= start_delay) begin
          bus.tx_busy_i <= 1'b1;
          busy_cnt      <= frame_len;
          wait_cnt      <= 0;
        end else begin
          wait_cnt <= wait_cnt + 1;
        end
      end
    end else if (busy_cnt <= 1) begin
      bus.tx_busy_i <= 1'b0;
    end else begin
      busy_cnt <= busy_cnt - 1;
    end
  end

  // Per-requester byte queues ({last, data}) and reference-model state.
  logic [W:0]  mem [N][32];
  int          head [N];
  int          tail [N];
  int          m_last;
  bit          m_lock;
  int          m_owner;
  int          accepts;
  int          frames_done;
  int          acc_log[$];
  logic [W-1:0] byte_log[$];

  function automatic void reset_model();
    for (int k = 0; k < N; k++) begin
      head[k] = 0;
      tail[k] = 0;
    end
    m_last      = N - 1;
    m_lock      = 1'b0;
    m_owner     = 0;
    accepts     = 0;
    frames_done = 0;
    acc_log.delete();
    byte_log.delete();
  endfunction

  function automatic void push(input int k, input bit last, input logic [W-1:0] data);
    mem[k][tail[k]] = {last, data};
    tail[k]++;
  endfunction

  function automatic bit all_empty();
    for (int k = 0; k < N; k++) if (head[k] != tail[k]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int model_pick(input logic [N-1:0] vm);
    for (int i = 1; i <= N; i++) begin
      int c;
      c = (m_last + i) % N;
      if (vm[c] && (!m_lock || c == m_owner)) return c;
    end
    return -1;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst             = 1'b1;
    bus.en_i        = 1'b1;
    bus.req_valid_i = '0;
    bus.req_data_i  = '0;
    bus.req_last_i  = '0;
    frame_len       = 3;
    start_delay     = 0;
    reset_model();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_idle(input int budget);
    int cyc;
    cyc = 0;
    while (bus.busy_o || bus.tx_busy_i) begin
      if (cyc == budget) begin
        miscompares++;
        $display("[TB] FAIL idle_timeout: still busy after %0d cycles, required idle", budget);
        return;
      end
      cyc++;
      @(negedge clk);
    end
  endtask

  // Drives the queued bytes cycle by cycle and checks every acceptance against the model.
  task automatic run_stream(input int budget, input bit rand_en);
    int cyc;
    int k;
    bit chk;
    logic [W-1:0] chk_byte;
    logic [N-1:0] chk_grant;
    logic [N-1:0] vm;
    logic [N-1:0] exp_ready;
    logic prev_busy;
    cyc = 0;
    chk = 1'b0;
    chk_byte = '0;
    chk_grant = '0;
    prev_busy = bus.tx_busy_i;
    while (!all_empty() || bus.busy_o || chk) begin
      if (cyc == budget) begin
        miscompares++;
        $display("[TB] FAIL stream_timeout: %0d cycles elapsed, required all queues drained", budget);
        break;
      end
      cyc++;
      @(negedge clk);
      if (prev_busy && !bus.tx_busy_i) frames_done++;
      prev_busy = bus.tx_busy_i;
      if (chk) begin
        vectors++;
        if (bus.tx_data_o !== chk_byte || bus.tx_send_o !== 1'b1 || bus.grant_o !== chk_grant) begin
          miscompares++;
          $display("[TB] FAIL stream_issue: data=%h send=%b grant=%b, required data=%h send=1 grant=%b",
                   bus.tx_data_o, bus.tx_send_o, bus.grant_o, chk_byte, chk_grant);
        end
        chk = 1'b0;
      end
      bus.en_i = rand_en ? ($urandom_range(0, 3) != 0) : 1'b1;
      for (int r = 0; r < N; r++) begin
        vm[r] = (head[r] != tail[r]);
        bus.req_valid_i[r] = vm[r];
        bus.req_data_i[r*W +: W] = vm[r] ? mem[r][head[r]][W-1:0] : W'($urandom);
        bus.req_last_i[r] = vm[r] ? mem[r][head[r]][W] : 1'b0;
      end
      #1;
      if (bus.req_ready_o !== '0) begin
        k = model_pick(vm);
        exp_ready = (k >= 0) ? (N'(1) << k) : '0;
        vectors++;
        if (!bus.en_i || bus.tx_busy_i || accepts != frames_done || bus.req_ready_o !== exp_ready) begin
          miscompares++;
          $display("[TB] FAIL stream_ready: ready=%b en=%b tx_busy=%b inflight=%0d, required ready=%b with en=1 tx_busy=0 inflight=0",
                   bus.req_ready_o, bus.en_i, bus.tx_busy_i, accepts - frames_done, exp_ready);
        end else begin
          accepts++;
          chk_byte  = mem[k][head[k]][W-1:0];
          chk_grant = exp_ready;
`ifdef UART_TX_ARB_LOCK_EN
          if (mem[k][head[k]][W]) begin
            m_lock = 1'b0;
          end else begin
            m_lock  = 1'b1;
            m_owner = k;
          end
`endif
          m_last = k;
          acc_log.push_back(k);
          byte_log.push_back(chk_byte);
          head[k]++;
          chk = 1'b1;
        end
      end
    end
    bus.req_valid_i = '0;
    bus.en_i        = 1'b1;
  endtask

  task automatic test_reset();
    rst             = 1'b1;
    bus.en_i        = 1'b1;
    bus.req_valid_i = '1;
    bus.req_data_i  = '1;
    bus.req_last_i  = '1;
    repeat (2) @(negedge clk);
    vectors += 5;
    if (bus.req_ready_o !== '0) begin miscompares++; $display("[TB] FAIL reset_ready: got %b, required 0", bus.req_ready_o); end
    if (bus.tx_data_o !== '0)   begin miscompares++; $display("[TB] FAIL reset_tx_data: got %h, required 0", bus.tx_data_o); end
    if (bus.tx_send_o !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_tx_send: got %b, required 0", bus.tx_send_o); end
    if (bus.grant_o !== '0)     begin miscompares++; $display("[TB] FAIL reset_grant: got %b, required 0", bus.grant_o); end
    if (bus.busy_o !== 1'b0)    begin miscompares++; $display("[TB] FAIL reset_busy: got %b, required 0", bus.busy_o); end
    rst = 1'b0;
    #1;
    vectors++;
    if (bus.req_ready_o !== '0) begin
      miscompares++;
      $display("[TB] FAIL ready_while_tx_busy: got %b, required 0", bus.req_ready_o);
    end
    bus.req_valid_i = '0;
    reset_model();
    @(negedge clk);
  endtask

  task automatic test_single();
    int ready_cycles;
    int send_cycles;
    bit grant_bad;
    do_reset();
    bus.req_valid_i[2]       = 1'b1;
    bus.req_data_i[2*W +: W] = 8'hA5;
    #1;
    vectors++;
    if (bus.req_ready_o !== 4'b0100) begin
      miscompares++;
      $display("[TB] FAIL single_ready: got %b, required 0100", bus.req_ready_o);
    end
    ready_cycles = (bus.req_ready_o != '0) ? 1 : 0;
    send_cycles  = 0;
    grant_bad    = 1'b0;
    @(negedge clk);
    bus.req_valid_i = '0;
    vectors++;
    if (bus.tx_data_o !== 8'hA5) begin
      miscompares++;
      $display("[TB] FAIL single_tx_data: got %h, required a5", bus.tx_data_o);
    end
    for (int i = 0; i < 20; i++) begin
      if (bus.req_ready_o != '0) ready_cycles++;
      if (bus.tx_send_o) send_cycles++;
      if ((bus.tx_send_o || bus.tx_busy_i) && bus.grant_o !== 4'b0100) grant_bad = 1'b1;
      @(negedge clk);
    end
    vectors += 5;
    if (ready_cycles != 1) begin miscompares++; $display("[TB] FAIL single_ready_cycles: got %0d, required 1", ready_cycles); end
    if (send_cycles != 2)  begin miscompares++; $display("[TB] FAIL single_send_cycles: got %0d, required 2", send_cycles); end
    if (grant_bad)         begin miscompares++; $display("[TB] FAIL single_grant_hold: grant left 0100 while in flight, required 0100"); end
    if (bus.grant_o !== '0) begin miscompares++; $display("[TB] FAIL single_grant_clear: got %b, required 0", bus.grant_o); end
    if (bus.busy_o !== 1'b0) begin miscompares++; $display("[TB] FAIL single_busy_clear: got %b, required 0", bus.busy_o); end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < N; k++) push(k, 1'b1, W'($urandom));
    run_stream(300, 1'b0);
    vectors++;
    if (acc_log.size() != 2 * N) begin
      miscompares++;
      $display("[TB] FAIL rr_count: got %0d grants, required %0d", acc_log.size(), 2 * N);
    end else begin
      for (int i = 0; i < 2 * N; i++) begin
        vectors++;
        if (acc_log[i] != i % N) begin
          miscompares++;
          $display("[TB] FAIL rr_order[%0d]: got requester %0d, required %0d", i, acc_log[i], i % N);
        end
      end
    end
  endtask

  task automatic test_en_low();
    do_reset();
    bus.en_i                 = 1'b0;
    bus.req_valid_i[1]       = 1'b1;
    bus.req_data_i[1*W +: W] = 8'h5C;
    for (int i = 0; i < 5; i++) begin
      #1;
      vectors++;
      if (bus.req_ready_o !== '0) begin
        miscompares++;
        $display("[TB] FAIL en_low_ready: got %b, required 0", bus.req_ready_o);
      end
      @(negedge clk);
    end
    bus.en_i = 1'b1;
    #1;
    vectors++;
    if (bus.req_ready_o !== 4'b0010) begin
      miscompares++;
      $display("[TB] FAIL en_rise_ready: got %b, required 0010", bus.req_ready_o);
    end
    @(negedge clk);
    bus.req_valid_i = '0;
    wait_idle(50);
  endtask

  task automatic test_en_drop_send();
    int held;
    do_reset();
    start_delay              = 4;
    bus.req_valid_i[0]       = 1'b1;
    bus.req_data_i[0*W +: W] = 8'h3C;
    #1;
    vectors++;
    if (bus.req_ready_o !== 4'b0001) begin
      miscompares++;
      $display("[TB] FAIL drop_accept: got %b, required 0001", bus.req_ready_o);
    end
    @(negedge clk);
    bus.en_i        = 1'b0;
    bus.req_valid_i = '0;
    held = 0;
    for (int i = 0; i < 20 && !bus.tx_busy_i; i++) begin
      vectors++;
      if (bus.tx_send_o !== 1'b1 || bus.tx_data_o !== 8'h3C) begin
        miscompares++;
        $display("[TB] FAIL drop_hold: send=%b data=%h, required send=1 data=3c", bus.tx_send_o, bus.tx_data_o);
      end
      held++;
      @(negedge clk);
    end
    vectors++;
    if (held != start_delay + 1) begin
      miscompares++;
      $display("[TB] FAIL drop_hold_len: got %0d cycles, required %0d", held, start_delay + 1);
    end
    bus.en_i    = 1'b1;
    start_delay = 0;
    wait_idle(50);
  endtask

  task automatic test_lock();
    logic [W-1:0] exp_seq [6];
    do_reset();
    push(1, 1'b0, 8'h10); push(1, 1'b0, 8'h11); push(1, 1'b1, 8'h12);
    push(3, 1'b1, 8'h30); push(3, 1'b1, 8'h31); push(3, 1'b1, 8'h32);
`ifdef UART_TX_ARB_LOCK_EN
    exp_seq = '{8'h10, 8'h11, 8'h12, 8'h30, 8'h31, 8'h32};
`else
    exp_seq = '{8'h10, 8'h30, 8'h11, 8'h31, 8'h12, 8'h32};
`endif
    run_stream(300, 1'b0);
    vectors++;
    if (byte_log.size() != 6) begin
      miscompares++;
      $display("[TB] FAIL lock_count: got %0d bytes, required 6", byte_log.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        vectors++;
        if (byte_log[i] !== exp_seq[i]) begin
          miscompares++;
          $display("[TB] FAIL lock_order[%0d]: got %h, required %h", i, byte_log[i], exp_seq[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    int cnt;
    do_reset();
    for (int round = 0; round < 4; round++) begin
      frame_len   = $urandom_range(1, 4);
      start_delay = $urandom_range(0, 2);
      for (int k = 0; k < N; k++) begin
        cnt = $urandom_range(0, 6);
        for (int j = 0; j < cnt; j++) push(k, (j == cnt - 1) ? 1'b1 : 1'($urandom), W'($urandom));
      end
      run_stream(3000, 1'b1);
    end
    start_delay = 0;
  endtask

  task automatic test_reset_mid_done();
    bit found;
    do_reset();
    frame_len                = 6;
    bus.req_valid_i[2]       = 1'b1;
    bus.req_data_i[2*W +: W] = 8'hC3;
    @(negedge clk);
    bus.req_valid_i = '0;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (bus.tx_busy_i && !bus.tx_send_o && bus.grant_o != '0) found = 1'b1;
      else @(negedge clk);
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("[TB] FAIL mid_done_reach: grant=%b send=%b, required frame in flight", bus.grant_o, bus.tx_send_o);
    end
    #2 rst = 1'b1;
    #1;
    vectors += 5;
    if (bus.req_ready_o !== '0) begin miscompares++; $display("[TB] FAIL mid_rst_ready: got %b, required 0", bus.req_ready_o); end
    if (bus.tx_data_o !== '0)   begin miscompares++; $display("[TB] FAIL mid_rst_tx_data: got %h, required 0", bus.tx_data_o); end
    if (bus.tx_send_o !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_rst_tx_send: got %b, required 0", bus.tx_send_o); end
    if (bus.grant_o !== '0)     begin miscompares++; $display("[TB] FAIL mid_rst_grant: got %b, required 0", bus.grant_o); end
    if (bus.busy_o !== 1'b0)    begin miscompares++; $display("[TB] FAIL mid_rst_busy: got %b, required 0", bus.busy_o); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    reset_model();
  endtask

  initial begin
    rst             = 1'b1;
    bus.en_i        = 1'b0;
    bus.req_valid_i = '0;
    bus.req_data_i  = '0;
    bus.req_last_i  = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_en_low();
    test_en_drop_send();
    test_lock();
    test_random();
    test_reset_mid_done();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
